// File: rtl/seq_pkg.sv
// seq_pkg: shared constants and helpers for the 0,8,5,3,7,2 sequence checker.
//   - 4-bit encodings of the six legal generator values
//   - FSM state encoding (SEARCH/LOCKED)
//   - is_legal(v): 1 when v belongs to the legal set
//   - succ(v):     next legal value in the cycle, 0 for an illegal input
package seq_pkg;

  localparam logic [3:0] V0 = 4'd0;
  localparam logic [3:0] V8 = 4'd8;
  localparam logic [3:0] V5 = 4'd5;
  localparam logic [3:0] V3 = 4'd3;
  localparam logic [3:0] V7 = 4'd7;
  localparam logic [3:0] V2 = 4'd2;

  localparam logic [0:0] SEARCH = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  function automatic logic is_legal(input logic [3:0] v);
    logic r;
    case (v)
      V0, V8, V5, V3, V7, V2: r = 1'b1;
      default:                r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] succ(input logic [3:0] v);
    logic [3:0] r;
    case (v)
      V0:      r = V8;
      V8:      r = V5;
      V5:      r = V3;
      V3:      r = V7;
      V7:      r = V2;
      V2:      r = V0;
      default: r = 4'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seq_successor.sv
// seq_successor: purely combinational successor/legality lookup.
// Ports:
//   value [3:0] in  - value to classify
//   next  [3:0] out - successor in the 0,8,5,3,7,2 cycle (0 if illegal)
//   legal       out - 1 when value is one of the six legal values
module seq_successor
  import seq_pkg::*;
(
  input  logic [3:0] value,
  output logic [3:0] next,
  output logic       legal
);

  // Table lookup for successor and legality of one value
  always_comb begin
    next  = succ(value);
    legal = is_legal(value);
  end

endmodule

// File: rtl/sequence_checker.sv
// sequence_checker: self-check stage behind the 0,8,5,3,7,2 generator.
// Locks after LOCK_COUNT consecutive correct transitions, then flags every
// out-of-order or illegal sample, counts violations and completed periods,
// and drops back to searching after a violation.
// Ports:
//   clock                 in  - system clock, posedge active
//   reset                 in  - asynchronous active-high clear
//   sample_en             in  - sample value on this posedge
//   value        [3:0]    in  - generator output under check
//   locked                out - 1 while in LOCKED
//   error                 out - one-cycle pulse per violation while locked
//   expected     [3:0]    out - predicted next value (0 without a valid sample)
//   err_count    [EW-1:0] out - saturating violation count
//   period_count [PW-1:0] out - saturating count of 2->0 wraps while locked
module sequence_checker
  import seq_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = 2,
  parameter int unsigned ERR_WIDTH  = 8,
  parameter int unsigned PER_WIDTH  = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 sample_en,
  input  logic [3:0]           value,
  output logic                 locked,
  output logic                 error,
  output logic [3:0]           expected,
  output logic [ERR_WIDTH-1:0] err_count,
  output logic [PER_WIDTH-1:0] period_count
);

  localparam int unsigned RUN_W = $clog2(LOCK_COUNT + 1);
  localparam logic [RUN_W-1:0] RUN_TARGET = RUN_W'(LOCK_COUNT);

  logic [0:0]           state_r, state_nx_s;
  logic [3:0]           prev_r, prev_nx_s;
  logic                 prev_valid_r, prev_valid_nx_s;
  logic [RUN_W-1:0]     run_r, run_nx_s, run_inc_s;
  logic                 error_r, error_nx_s;
  logic [3:0]           expected_r, expected_nx_s;
  logic [ERR_WIDTH-1:0] errc_r, errc_nx_s, errc_sat_s;
  logic [PER_WIDTH-1:0] perc_r, perc_nx_s, perc_sat_s;

  logic [3:0] prev_next_s, value_next_s;
  logic       prev_legal_s, value_legal_s, match_s;

  // Prediction from the last accepted sample
  seq_successor u_prev_succ (
    .value (prev_r),
    .next  (prev_next_s),
    .legal (prev_legal_s)
  );

  // Classification of the incoming sample; its successor seeds the next prediction
  seq_successor u_value_succ (
    .value (value),
    .next  (value_next_s),
    .legal (value_legal_s)
  );

  // Match, increment and saturating-increment helpers
  always_comb begin
    match_s    = prev_valid_r & prev_legal_s & value_legal_s & (value == prev_next_s);
    run_inc_s  = run_r + RUN_W'(1);
    errc_sat_s = (errc_r != {ERR_WIDTH{1'b1}}) ? errc_r + ERR_WIDTH'(1) : errc_r;
    perc_sat_s = (perc_r != {PER_WIDTH{1'b1}}) ? perc_r + PER_WIDTH'(1) : perc_r;
  end

  // Next-state logic for the lock FSM, prediction and counters
  always_comb begin
    state_nx_s      = state_r;
    prev_nx_s       = prev_r;
    prev_valid_nx_s = prev_valid_r;
    run_nx_s        = run_r;
    error_nx_s      = 1'b0;
    expected_nx_s   = expected_r;
    errc_nx_s       = errc_r;
    perc_nx_s       = perc_r;
    if (sample_en) begin
      case (state_r)
        SEARCH: begin
          if (!value_legal_s) begin
            prev_valid_nx_s = 1'b0;
            run_nx_s        = {RUN_W{1'b0}};
            expected_nx_s   = 4'd0;
          end else begin
            prev_nx_s       = value;
            prev_valid_nx_s = 1'b1;
            expected_nx_s   = value_next_s;
            if (match_s) begin
              if (run_inc_s == RUN_TARGET) begin
                state_nx_s = LOCKED;
                run_nx_s   = {RUN_W{1'b0}};
              end else begin
                run_nx_s   = run_inc_s;
              end
            end else begin
              run_nx_s = {RUN_W{1'b0}};
            end
          end
        end
        LOCKED: begin
          prev_nx_s = value;
          if (match_s) begin
            expected_nx_s = value_next_s;
            // A correct step out of 2 is the wrap back to 0: one full period
            if (prev_r == V2) begin
              perc_nx_s = perc_sat_s;
            end else begin
              perc_nx_s = perc_r;
            end
          end else begin
            error_nx_s      = 1'b1;
            errc_nx_s       = errc_sat_s;
            state_nx_s      = SEARCH;
            run_nx_s        = {RUN_W{1'b0}};
            prev_valid_nx_s = value_legal_s;
            // A legal offending value seeds the next search
            expected_nx_s   = value_legal_s ? value_next_s : 4'd0;
          end
        end
        default: begin
          state_nx_s      = SEARCH;
          prev_valid_nx_s = 1'b0;
          run_nx_s        = {RUN_W{1'b0}};
          expected_nx_s   = 4'd0;
        end
      endcase
    end else begin
      error_nx_s = 1'b0;
    end
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= SEARCH;
      prev_r       <= 4'd0;
      prev_valid_r <= 1'b0;
      run_r        <= {RUN_W{1'b0}};
      error_r      <= 1'b0;
      expected_r   <= 4'd0;
      errc_r       <= {ERR_WIDTH{1'b0}};
      perc_r       <= {PER_WIDTH{1'b0}};
    end else begin
      state_r      <= state_nx_s;
      prev_r       <= prev_nx_s;
      prev_valid_r <= prev_valid_nx_s;
      run_r        <= run_nx_s;
      error_r      <= error_nx_s;
      expected_r   <= expected_nx_s;
      errc_r       <= errc_nx_s;
      perc_r       <= perc_nx_s;
    end
  end

  // Output mapping
  always_comb begin
    locked       = (state_r == LOCKED);
    error        = error_r;
    expected     = expected_r;
    err_count    = errc_r;
    period_count = perc_r;
  end

endmodule

// File: tb/tb_sequence_checker.sv
// tb_sequence_checker: directed, scoreboard-checked bench for sequence_checker
// (LOCK_COUNT=2, ERR_WIDTH=2 so error-counter saturation is reachable).
module tb_sequence_checker;

  logic       clock;
  logic       reset;
  logic       sample_en;
  logic [3:0] value;
  logic       locked;
  logic       error;
  logic [3:0] expected;
  logic [1:0] err_count;
  logic [7:0] period_count;

  typedef struct packed {
    logic       l;
    logic       e;
    logic [3:0] x;
    logic [1:0] ec;
    logic [7:0] pc;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    tests;
  int    fails;

  sequence_checker #(
    .LOCK_COUNT (2),
    .ERR_WIDTH  (2),
    .PER_WIDTH  (8)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .sample_en    (sample_en),
    .value        (value),
    .locked       (locked),
    .error        (error),
    .expected     (expected),
    .err_count    (err_count),
    .period_count (period_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cmp(input string nm, input string fld, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s.%s: got %0d, expected %0d", nm, fld, act, req);
    end
  endtask

  task automatic chk_all(input string nm, input exp_t e);
    cmp(nm, "locked",       int'(locked),       int'(e.l));
    cmp(nm, "error",        int'(error),        int'(e.e));
    cmp(nm, "expected",     int'(expected),     int'(e.x));
    cmp(nm, "err_count",    int'(err_count),    int'(e.ec));
    cmp(nm, "period_count", int'(period_count), int'(e.pc));
  endtask

  // Monitor: one output set per posedge, checked against the oldest queued expectation
  always @(posedge clock) begin
    #1;
    if (exp_q.size() != 0) begin
      exp_t  e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      chk_all(n, e);
    end
  end

  // Drive one cycle of stimulus and queue the response expected after the next posedge
  task automatic step(input logic en, input logic [3:0] v,
                      input logic l, input logic e, input logic [3:0] x,
                      input logic [1:0] ec, input logic [7:0] pc, input string nm);
    exp_t t;
    @(negedge clock);
    sample_en = en;
    value     = v;
    t.l = l; t.e = e; t.x = x; t.ec = ec; t.pc = pc;
    exp_q.push_back(t);
    name_q.push_back(nm);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clock);
    #3;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
  endtask

  initial begin
    exp_t  z;
    logic [1:0] ec;
    tests = 0;
    fails = 0;
    z = '0;
    reset = 1'b1; sample_en = 1'b0; value = 4'd0;
    #12;
    chk_all("reset_high", z);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk_all("reset_release", z);

    // Acquire lock on 0,8,5
    step(1'b1, 4'd0, 1'b0, 1'b0, 4'd8, 2'd0, 8'd0, "t1_s0");
    step(1'b1, 4'd8, 1'b0, 1'b0, 4'd5, 2'd0, 8'd0, "t1_s8");
    step(1'b1, 4'd5, 1'b1, 1'b0, 4'd3, 2'd0, 8'd0, "t1_s5");
    // Run through a wrap while locked
    step(1'b1, 4'd3, 1'b1, 1'b0, 4'd7, 2'd0, 8'd0, "t2_s3");
    step(1'b1, 4'd7, 1'b1, 1'b0, 4'd2, 2'd0, 8'd0, "t2_s7");
    step(1'b1, 4'd2, 1'b1, 1'b0, 4'd0, 2'd0, 8'd0, "t2_s2");
    step(1'b1, 4'd0, 1'b1, 1'b0, 4'd8, 2'd0, 8'd1, "t2_s0");
    step(1'b1, 4'd8, 1'b1, 1'b0, 4'd5, 2'd0, 8'd1, "t2_s8");
    // Skip 5: violation on 3, which then seeds relock via 7,2
    step(1'b1, 4'd3, 1'b0, 1'b1, 4'd7, 2'd1, 8'd1, "t3_s3");
    step(1'b1, 4'd7, 1'b0, 1'b0, 4'd2, 2'd1, 8'd1, "t3_s7");
    step(1'b1, 4'd2, 1'b1, 1'b0, 4'd0, 2'd1, 8'd1, "t3_s2");
    // Illegal 4 while locked, then search with an illegal value in the run
    step(1'b1, 4'd4, 1'b0, 1'b1, 4'd0, 2'd2, 8'd1, "t4_s4l");
    step(1'b1, 4'd0, 1'b0, 1'b0, 4'd8, 2'd2, 8'd1, "t4_s0");
    step(1'b1, 4'd4, 1'b0, 1'b0, 4'd0, 2'd2, 8'd1, "t4_s4");
    step(1'b1, 4'd8, 1'b0, 1'b0, 4'd5, 2'd2, 8'd1, "t4_s8");
    step(1'b1, 4'd5, 1'b0, 1'b0, 4'd3, 2'd2, 8'd1, "t4_s5");
    step(1'b1, 4'd3, 1'b1, 1'b0, 4'd7, 2'd2, 8'd1, "t4_s3");
    // Gated gap with a value that would be illegal if sampled
    step(1'b1, 4'd7, 1'b1, 1'b0, 4'd2, 2'd2, 8'd1, "t5_s7");
    step(1'b1, 4'd2, 1'b1, 1'b0, 4'd0, 2'd2, 8'd1, "t5_s2");
    step(1'b1, 4'd0, 1'b1, 1'b0, 4'd8, 2'd2, 8'd2, "t5_s0");
    for (int i = 0; i < 3; i++)
      step(1'b0, 4'd15, 1'b1, 1'b0, 4'd8, 2'd2, 8'd2, "t5_gap");
    step(1'b1, 4'd8, 1'b1, 1'b0, 4'd5, 2'd2, 8'd2, "t5_s8");
    step(1'b1, 4'd5, 1'b1, 1'b0, 4'd3, 2'd2, 8'd2, "t5_s5");
    // Five violations with relock in between; 2-bit counter saturates at 3
    ec = 2'd2;
    for (int i = 0; i < 5; i++) begin
      ec = (ec == 2'd3) ? 2'd3 : ec + 2'd1;
      step(1'b1, 4'd15, 1'b0, 1'b1, 4'd0, ec, 8'd2, "t6_viol");
      step(1'b1, 4'd0,  1'b0, 1'b0, 4'd8, ec, 8'd2, "t6_s0");
      step(1'b1, 4'd8,  1'b0, 1'b0, 4'd5, ec, 8'd2, "t6_s8");
      step(1'b1, 4'd5,  1'b1, 1'b0, 4'd3, ec, 8'd2, "t6_s5");
    end
    step(1'b0, 4'd0, 1'b1, 1'b0, 4'd3, 2'd3, 8'd2, "t6_hold");
    drain();

    // Asynchronous reset between edges while locked
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    chk_all("t6_async_reset", z);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk_all("t6_after_reset", z);
    step(1'b1, 4'd0, 1'b0, 1'b0, 4'd8, 2'd0, 8'd0, "t7_s0");
    step(1'b0, 4'd0, 1'b0, 1'b0, 4'd8, 2'd0, 8'd0, "t7_hold");
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sequence_checker.md
Name: sequence_checker

Overview:
Downstream consumer of the 4-bit binary sequence generator, which produces 0,8,5,3,7,2 and repeats. Samples the generator's 4-bit output and acquires lock after a run of correct successor transitions. Once locked, flags every out-of-order or illegal value, counts errors and completed periods, and re-acquires lock automatically. Sits between the generator and the lab display/LED logic as a self-check stage.

Parameters:
LOCK_COUNT, 2, consecutive correct successor transitions required to enter LOCKED (legal range >= 1)
ERR_WIDTH, 8, width of the saturating error counter
PER_WIDTH, 8, width of the saturating completed-period counter

Ports:
clock  input  1  system clock; all state changes on posedge
reset  input  1  asynchronous, active-high; clears all state immediately
sample_en  input  1  value is sampled on a posedge only when this is 1
value  input  4  generator output under check
locked  output  1  1 while in LOCKED state
error  output  1  one-cycle pulse on a detected sequence violation while locked
expected  output  4  predicted next value; 0 when no valid previous sample exists
err_count  output  ERR_WIDTH  saturating count of violations
period_count  output  PER_WIDTH  saturating count of 2->0 wraps observed while locked

Behaviour:
- Legal set {0,8,5,3,7,2}. Successor map: 0->8, 8->5, 5->3, 3->7, 7->2, 2->0. Any other value is illegal.
- Internal state: state {SEARCH, LOCKED}, prev[3:0], prev_valid, run_cnt (enough bits to hold LOCK_COUNT).
- Reset (async, any time, including mid-operation): state=SEARCH, prev=0, prev_valid=0, run_cnt=0. All outputs are 0 while reset is high and immediately after it deasserts.
- All outputs are registered. Effects of a sample are visible after the posedge that samples it (1-cycle latency).
- sample_en=0: all state, counters, locked and expected hold; error is driven to 0.
- SEARCH, sample_en=1:
  - value illegal: prev_valid<=0, run_cnt<=0.
  - value legal, prev_valid=1, value==succ(prev): run_cnt increments. If the new run_cnt equals LOCK_COUNT, state<=LOCKED, run_cnt<=0.
  - value legal otherwise: run_cnt<=0.
  - In both legal cases: prev<=value, prev_valid<=1.
  - No error pulses in SEARCH. Counters are untouched.
- LOCKED, sample_en=1:
  - value==succ(prev): prev<=value. If prev==2 (wrap to 0), period_count increments, saturating at all-ones.
  - otherwise: error<=1 for one cycle; err_count increments, saturating at all-ones; state<=SEARCH; run_cnt<=0; prev<=value; prev_valid<=legal(value).
- expected = succ(prev) when prev_valid=1, else 0.
- locked reflects state (LOCKED=1).
- Counters never wrap. They are cleared only by reset.
- An error sample that is legal seeds the new search, so relock can need as few as LOCK_COUNT further correct samples.

Decomposition:
- Package seq_pkg holds:
  - 4-bit constants for the six legal values;
  - state encoding (SEARCH=0, LOCKED=1);
  - functions is_legal(v) and succ(v), where succ of an illegal value returns 0.
- One combinational sub-module, seq_successor (in: value[3:0]; out: next[3:0], legal), instantiated twice: once for prev (prediction) and once for legality of the incoming sample.
- FSM, counters and registers stay in sequence_checker.

Test Plan:
1. Reset; LOCK_COUNT=2; sample 0,8,5 on consecutive edges with sample_en=1 -> locked=0 after 0 and 8, locked=1 after 5, expected=3, err_count=0.
2. Continue 3,7,2,0,8 -> no error; period_count=1 after the 0 sample; expected=5 at the end.
3. While locked, sample 8 then 3 (5 skipped) -> error=1 for exactly one cycle after the 3 sample, err_count=1, locked=0, expected=7. Then 7,2 -> locked=1 again.
4. In SEARCH, sample 0,4,8,5 -> 4 is illegal, so no error and the run is cleared; locked=0 after 8; lock on the next 3 (sequence 8,5,3 is two correct transitions), with no error throughout.
5. Sample 0; hold sample_en=0 for 3 cycles with value=15; then sample 8,5 -> no error, locked=1 after 5, and counters unchanged during the gap.
6. ERR_WIDTH=2: force 5 violations, relocking between each -> err_count saturates at 3. Assert reset mid-LOCKED between edges -> locked, err_count, period_count and expected drop to 0 without a clock edge.
